// File: rtl/data_mem_port.sv
// data_mem_port: MEM-stage load/store responder. Turns byte/half/word
// loads and stores into aligned word requests on a handshaked data bus,
// returns extended load data and stalls the pipeline while a request is open.
module data_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            MAIN_MEM_READ,
  input  logic [2:0]            MAIN_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSY,
  output logic                  ACCESS_FAULT,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-3:0] MEM_ADDR,
  output logic [31:0]           MEM_WDATA,
  output logic [3:0]            MEM_BYTE_EN,
  input  logic [31:0]           MEM_RDATA,
  input  logic                  MEM_ACK
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  // Last counter value before the wait budget is exhausted.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t                state_reg, state_next;
  logic                  req_reg, req_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-3:0] addr_reg, addr_next;
  logic [3:0]            be_reg, be_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [2:0]            ltype_reg, ltype_next;
  logic [1:0]            off_reg, off_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  fault_reg, fault_next;

  logic        store_en;
  logic        req;
  logic        store_legal;
  logic        load_legal;
  logic        legal;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  // A store takes priority when both enables are raised together.
  assign store_en = MAIN_MEM_WRITE[2];
  assign req      = MAIN_MEM_WRITE[2] | MAIN_MEM_READ[3];

  // Encoding and alignment legality for the request on the inputs.
  always_comb begin
    store_legal = 1'b0;
    load_legal  = 1'b0;
    case (MAIN_MEM_WRITE[1:0])
      2'b00:   store_legal = 1'b1;
      2'b01:   store_legal = ~ADDRESS[0];
      2'b10:   store_legal = (ADDRESS[1:0] == 2'b00);
      default: store_legal = 1'b0;
    endcase
    case (MAIN_MEM_READ[2:0])
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~ADDRESS[0];
      3'b010:         load_legal = (ADDRESS[1:0] == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  end

  assign legal = store_en ? store_legal : load_legal;

  // Byte-lane enables for the store size and offset.
  always_comb begin
    case (MAIN_MEM_WRITE[1:0])
      2'b00:   store_be = 4'b0001 << ADDRESS[1:0];
      2'b01:   store_be = ADDRESS[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  end

  // Replicate the low store bits across every lane so any enabled lane is right.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_wdata[gi*8 +: 8] =
      (MAIN_MEM_WRITE[1:0] == 2'b00) ? WRITE_DATA[7:0] :
      (MAIN_MEM_WRITE[1:0] == 2'b01) ? WRITE_DATA[(gi % 2)*8 +: 8] :
                                       WRITE_DATA[gi*8 +: 8];
  end

  assign sel_byte = MEM_RDATA[{off_reg, 3'b000} +: 8];
  assign sel_half = MEM_RDATA[{off_reg[1], 4'b0000} +: 16];

  // Extract and extend the addressed byte/half from the returned word.
  always_comb begin
    case (ltype_reg)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h0, sel_byte};
      3'b101:  load_ext = {16'h0, sel_half};
      default: load_ext = MEM_RDATA;
    endcase
  end

  // Next-state and next-register logic of the request FSM.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    ltype_next = ltype_reg;
    off_next   = off_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    fault_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (legal) begin
            state_next = ST_WAIT;
            req_next   = 1'b1;
            we_next    = store_en;
            addr_next  = ADDRESS[ADDR_WIDTH-1:2];
            be_next    = store_en ? store_be : 4'b1111;
            wdata_next = store_en ? store_wdata : 32'h0;
            ltype_next = MAIN_MEM_READ[2:0];
            off_next   = ADDRESS[1:0];
            cnt_next   = 8'h0;
          end else begin
            fault_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (MEM_ACK) begin
          req_next   = 1'b0;
          state_next = ST_DONE;
          if (!we_reg) begin
            rdata_next = load_ext;
          end
        end else if (cnt_reg == LAST_WAIT) begin
          req_next   = 1'b0;
          fault_next = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 8'h1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and bus registers; reset abandons any open request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= 4'h0;
      wdata_reg <= 32'h0;
      ltype_reg <= 3'h0;
      off_reg   <= 2'h0;
      cnt_reg   <= 8'h0;
      rdata_reg <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      ltype_reg <= ltype_next;
      off_reg   <= off_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      fault_reg <= fault_next;
    end
  end

  // Stall immediately when a legal request is accepted, and throughout WAIT.
  assign BUSY = (state_reg == ST_WAIT) |
                ((state_reg == ST_IDLE) & req & legal);

  assign READ_DATA    = rdata_reg;
  assign ACCESS_FAULT = fault_reg;
  assign MEM_REQ      = req_reg;
  assign MEM_WE       = we_reg;
  assign MEM_ADDR     = addr_reg;
  assign MEM_WDATA    = wdata_reg;
  assign MEM_BYTE_EN  = be_reg;

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Responder for the control unit's main_mem_read/main_mem_write encodings in the MEM stage of the RV32IM pipeline.
- Converts byte, half and word loads and stores into aligned word requests on a handshaked data-memory bus.
- Returns sign- or zero-extended load data.
- Stalls the pipeline via BUSY while a bus transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of ADDRESS; MEM_ADDR is ADDR_WIDTH-2 bits (word address).
- MAX_WAIT, 15, maximum wait cycles for MEM_ACK before abort (1..255).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- MAIN_MEM_READ  input  4  [3]=load enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- MAIN_MEM_WRITE  input  3  [2]=store enable, [1:0]=size (00 SB, 01 SH, 10 SW).
- ADDRESS  input  ADDR_WIDTH  byte address (ALU result).
- WRITE_DATA  input  32  store data from rs2; low bits are significant.
- READ_DATA  output  32  extended load result, registered.
- BUSY  output  1  pipeline stall request.
- ACCESS_FAULT  output  1  one-cycle pulse: misaligned, illegal encoding or timeout.
- MEM_REQ  output  1  bus request.
- MEM_WE  output  1  1=write, 0=read.
- MEM_ADDR  output  ADDR_WIDTH-2  word address = ADDRESS[ADDR_WIDTH-1:2].
- MEM_WDATA  output  32  lane-aligned store data.
- MEM_BYTE_EN  output  4  byte lane enables.
- MEM_RDATA  input  32  read word; valid when MEM_ACK=1.
- MEM_ACK  input  1  completes the current request.

Behaviour:
- Reset (RESET=0, asynchronous) forces:
  - state IDLE, wait counter 0;
  - READ_DATA=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_BYTE_EN=0, ACCESS_FAULT=0.
  - Reset mid-transaction abandons the request; a later MEM_ACK is ignored.
- Request detection:
  - req = MAIN_MEM_WRITE[2] | MAIN_MEM_READ[3].
  - If both enables are set, the store wins and the load is ignored.
- Legality check:
  - Loads: funct3 011/110/111 are illegal.
  - Stores: size 11 is illegal.
  - Misaligned: halfword with ADDRESS[0]=1; word with ADDRESS[1:0]!=00.
- States: IDLE, WAIT, DONE.
- IDLE:
  - req and legal: register MEM_ADDR, MEM_WE, MEM_BYTE_EN, MEM_WDATA, the load type and ADDRESS[1:0]; set MEM_REQ=1; clear the counter; go to WAIT.
  - BUSY=1 combinationally in this same cycle.
  - req and illegal or misaligned: no bus request; ACCESS_FAULT=1 next cycle for exactly one cycle; stay in IDLE; BUSY=0; READ_DATA unchanged.
  - No req: BUSY=0; MEM_ACK is ignored.
- WAIT:
  - BUSY=1; MEM_REQ and all MEM_* outputs held stable.
  - MEM_ACK=1: drop MEM_REQ next edge. For a load, register the extended read data into READ_DATA. Go to DONE.
  - No ack: increment the counter. When the counter reaches MAX_WAIT without an ack, drop MEM_REQ, pulse ACCESS_FAULT, leave READ_DATA unchanged, go to DONE.
  - An ack and the timeout in the same cycle: the ack wins.
- DONE:
  - BUSY=0 for exactly one cycle so the pipeline advances.
  - Inputs are ignored; no new request is issued from DONE.
  - Next state is IDLE.
- Latency: with MEM_ACK arriving k cycles after MEM_REQ rises, BUSY is high for k+1 cycles; READ_DATA is valid in DONE.
- Store lane mapping:
  - SB: BYTE_EN = 0001 << ADDRESS[1:0]; WDATA = {4{WRITE_DATA[7:0]}}.
  - SH: BYTE_EN = 0011 or 1100 per ADDRESS[1]; WDATA = {2{WRITE_DATA[15:0]}}.
  - SW: BYTE_EN = 1111; WDATA = WRITE_DATA.
- Load extraction:
  - Select the byte or halfword at offset ADDRESS[1:0] of MEM_RDATA.
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: whole word.
- MEM_BYTE_EN for a read is 1111; the bus ignores it.
- A store never modifies READ_DATA.

Test Plan:
- LW at 0x100, ack after 2 cycles with MEM_RDATA=0xDEADBEEF:
  - MEM_ADDR=0x40, MEM_WE=0, BUSY high for 3 cycles;
  - READ_DATA=0xDEADBEEF in DONE.
- LB at 0x103 with MEM_RDATA=0x80112233 -> READ_DATA=0xFFFFFF80. LBU at 0x103 -> READ_DATA=0x00000080. LHU at 0x102 -> READ_DATA=0x00008011.
- SB at 0x201 with WRITE_DATA=0x000000A5:
  - BYTE_EN=0010, MEM_WDATA=0xA5A5A5A5, MEM_WE=1.
  - SH at 0x202 -> BYTE_EN=1100.
- LW at 0x102 -> no MEM_REQ, ACCESS_FAULT pulses one cycle, BUSY stays 0. Load funct3=011 -> same response.
- Load with no ack, MAX_WAIT=15:
  - MEM_REQ drops after 15 wait cycles; ACCESS_FAULT pulses; BUSY low in the next (DONE) cycle; READ_DATA unchanged.
- RESET low while in WAIT:
  - MEM_REQ=0 and READ_DATA=0 immediately;
  - MEM_ACK arriving after RESET is released causes no state change or READ_DATA update.
